// File: rtl/wb_stage.sv
// Write-back / exception-commit stage: retires to the RF or traps and drains.
// Optional macro WB_MINSTRET_EN builds the 64-bit minstret counter.
module wb_stage #(
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [31:0] PC_MEM,
  input  logic [31:0] IR_MEM,
  input  logic [5:0]  rd_addr_MEM,
  input  logic [31:0] rd_data_MEM,
  input  logic        rd_access_MEM,
  input  logic [31:0] mem_addr_MEM,
  input  logic        mem_store_MEM,
  input  logic        illegal_inst_MEM,
  input  logic        maligned_inst_addr_MEM,
  input  logic        maligned_data_addr_MEM,
  input  logic [1:0]  imem_axi_rresp_MEM,
  input  logic [1:0]  dmem_axi_rresp_MEM,
  input  logic [1:0]  dmem_axi_bresp_MEM,
  output logic [5:0]  rd_addr_WB,
  output logic [31:0] rd_data_WB,
  output logic        rd_access_WB,
  output logic        trap_taken,
  output logic [31:0] trap_addr,
  input  logic        trap_ack,
  output logic [31:0] mepc,
  output logic [31:0] mtval,
  output logic [3:0]  mcause,
  output logic [63:0] minstret
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] REDIRECT = 2'd1;
  localparam logic [1:0] DRAIN    = 2'd2;

  localparam logic [3:0] DRAIN_W = 4'(DRAIN_CYCLES);

  logic [1:0]  state;
  logic [3:0]  drain_cnt;
  logic        is_load;
  logic        mem_op;
  logic        fault;
  logic [3:0]  cause;
  logic [31:0] tval;
  logic        unused_resp;

  assign ready_out = 1'b1;
  assign trap_addr = TRAP_VEC;

  // Only bit 1 of an AXI response distinguishes SLVERR/DECERR.
  assign unused_resp = ^{imem_axi_rresp_MEM[0],
                         dmem_axi_rresp_MEM[0],
                         dmem_axi_bresp_MEM[0]};

  always_comb begin
    is_load = (IR_MEM[6:0] == 7'b0000011);
    mem_op  = mem_store_MEM | is_load;
    fault   = 1'b1;
    cause   = 4'd0;
    tval    = PC_MEM;
    if (imem_axi_rresp_MEM[1]) begin
      cause = 4'd1;
      tval  = PC_MEM;
    end else if (illegal_inst_MEM) begin
      cause = 4'd2;
      tval  = IR_MEM;
    end else if (maligned_inst_addr_MEM) begin
      cause = 4'd0;
      tval  = PC_MEM;
    end else if (maligned_data_addr_MEM) begin
      cause = mem_store_MEM ? 4'd6 : 4'd4;
      tval  = mem_addr_MEM;
    end else if (mem_op && mem_store_MEM
                 && dmem_axi_bresp_MEM[1]) begin
      cause = 4'd7;
      tval  = mem_addr_MEM;
    end else if (mem_op && !mem_store_MEM
                 && dmem_axi_rresp_MEM[1]) begin
      cause = 4'd5;
      tval  = mem_addr_MEM;
    end else begin
      fault = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      drain_cnt    <= 4'd0;
      trap_taken   <= 1'b0;
      rd_access_WB <= 1'b0;
      rd_addr_WB   <= 6'd0;
      rd_data_WB   <= 32'd0;
      mepc         <= 32'd0;
      mcause       <= 4'd0;
      mtval        <= 32'd0;
    end else begin
      rd_access_WB <= 1'b0;
      case (state)
        RUN: begin
          if (valid_in) begin
            if (fault) begin
              mepc       <= PC_MEM;
              mcause     <= cause;
              mtval      <= tval;
              trap_taken <= 1'b1;
              state      <= REDIRECT;
            end else begin
              rd_access_WB <= rd_access_MEM
                              & (|rd_addr_MEM);
              rd_addr_WB   <= rd_addr_MEM;
              rd_data_WB   <= rd_data_MEM;
            end
          end
        end
        REDIRECT: begin
          if (trap_ack) begin
            trap_taken <= 1'b0;
            if (DRAIN_W == 4'd0) begin
              state <= RUN;
            end else begin
              drain_cnt <= DRAIN_W;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Bubbles do not count; only real wrong-path slots do.
          if (valid_in) begin
            drain_cnt <= drain_cnt - 4'd1;
            if (drain_cnt <= 4'd1) begin
              state <= RUN;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef WB_MINSTRET_EN
  logic commit;

  assign commit = (state == RUN) & valid_in & ~fault;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      minstret <= 64'd0;
    end else if (commit) begin
      minstret <= minstret + 64'd1;
    end
  end
`else
  assign minstret = 64'h0;
`endif

endmodule
